// File: rtl/sha_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha_pkg : shared SHA padding types, constants and padder states      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sha_pkg;

  localparam int unsigned SHA_BLOCK_BITS = 512;
  localparam int unsigned SHA_WORD_W     = 32;
  localparam int unsigned SHA_LEN_W      = 64;
  localparam logic [7:0]  SHA_PAD_MARK   = 8'h80;

  typedef logic [SHA_WORD_W-1:0] sha_word_t;
  typedef sha_word_t [0:15]      sha_block_t;

  localparam sha_word_t SHA_MARK_WORD = {SHA_PAD_MARK, 24'h000000};

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    EMIT_SPILL = 2'd2,
    EMIT_LAST  = 2'd3
  } padder_state_e;

endpackage : sha_pkg
`default_nettype wire

// File: rtl/sha_pad_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha_pad_word : masks a final partial word and inserts the 0x80 mark  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sha_pad_word
  import sha_pkg::*;
(
  input  logic [31:0] in_word,
  input  logic [2:0]  in_bytes,
  output logic [31:0] pad_word,
  output logic        marker_placed
);

  // Caller clamps in_bytes to 0..4; 4 means a full word with no room for the mark.
  always_comb begin
    pad_word      = in_word;
    marker_placed = 1'b0;
    case (in_bytes)
      3'd0: begin
        pad_word      = {SHA_PAD_MARK, 24'h000000};
        marker_placed = 1'b1;
      end
      3'd1: begin
        pad_word      = {in_word[31:24], SHA_PAD_MARK, 16'h0000};
        marker_placed = 1'b1;
      end
      3'd2: begin
        pad_word      = {in_word[31:16], SHA_PAD_MARK, 8'h00};
        marker_placed = 1'b1;
      end
      3'd3: begin
        pad_word      = {in_word[31:8], SHA_PAD_MARK};
        marker_placed = 1'b1;
      end
      default: begin
        pad_word      = in_word;
        marker_placed = 1'b0;
      end
    endcase
  end

endmodule : sha_pad_word
`default_nettype wire

// File: rtl/sha_msg_padder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha_msg_padder : frames a word stream into padded 512-bit SHA blocks |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned LEN_W       = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               s_data,
  input  logic [2:0]                s_bytes,
  input  logic                      s_last,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [SHA_BLOCK_BITS-1:0] m_block,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [SHA_LEN_W-1:0]      m_len_bits
);

  if (BLOCK_WORDS != 16 || LEN_W != 64) begin : g_param_check
    $error("sha_msg_padder supports only BLOCK_WORDS=16 and LEN_W=64");
  end

  padder_state_e  state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [63:0]    len_q, len_d;
  sha_block_t     buf_q, buf_d;
  logic           marker_q, marker_d;

  logic           in_fire, out_fire;
  logic [2:0]     eff_bytes;
  logic [63:0]    len_upd;
  logic [31:0]    pad_word;
  logic           marker_placed;
  logic [4:0]     idx_ext;
  logic [4:0]     mark_pos;

  assign s_ready    = (state_q == FILL);
  assign m_valid    = (state_q != FILL);
  assign m_last     = (state_q == EMIT_LAST);
  assign m_block    = buf_q;
  assign m_len_bits = len_q;

  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid && m_ready;

  // Out-of-range byte counts, and short words that are not last, count as full words.
  assign eff_bytes = (s_last && s_bytes <= 3'd4) ? s_bytes : 3'd4;
  assign len_upd   = len_q + {58'd0, eff_bytes, 3'b000};
  assign idx_ext   = {1'b0, idx_q};
  assign mark_pos  = idx_ext + (marker_placed ? 5'd0 : 5'd1);

  sha_pad_word u_pad_word (
    .in_word       (s_data),
    .in_bytes      (eff_bytes),
    .pad_word      (pad_word),
    .marker_placed (marker_placed)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    buf_d    = buf_q;
    marker_d = marker_q;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          len_d = len_upd;
          if (!s_last) begin
            buf_d[idx_q] = s_data;
            idx_d        = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d = EMIT;
            end
          end else begin
            for (int j = 0; j < 16; j++) begin
              if (5'(j) == idx_ext) begin
                buf_d[j] = pad_word;
              end else if (5'(j) > idx_ext) begin
                buf_d[j] = (!marker_placed && 5'(j) == idx_ext + 5'd1) ? SHA_MARK_WORD : '0;
              end
            end
            idx_d = 4'd0;
            // Length fits only when the marker landed at or before word 13.
            if (mark_pos <= 5'd13) begin
              buf_d[14] = len_upd[63:32];
              buf_d[15] = len_upd[31:0];
              state_d   = EMIT_LAST;
            end else begin
              marker_d = (mark_pos <= 5'd15);
              state_d  = EMIT_SPILL;
            end
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          state_d = FILL;
        end
      end
      EMIT_SPILL: begin
        if (out_fire) begin
          buf_d     = '0;
          buf_d[0]  = marker_q ? '0 : SHA_MARK_WORD;
          buf_d[14] = len_q[63:32];
          buf_d[15] = len_q[31:0];
          state_d   = EMIT_LAST;
        end
      end
      EMIT_LAST: begin
        if (out_fire) begin
          state_d = FILL;
          idx_d   = 4'd0;
          len_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      idx_q    <= 4'd0;
      len_q    <= '0;
      buf_q    <= '0;
      marker_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      buf_q    <= buf_d;
      marker_q <= marker_d;
    end
  end

  a_legal_bytes : assert property (@(posedge clk) disable iff (rst)
    (s_valid && s_ready) |-> ((s_bytes <= 3'd4) && (s_last || s_bytes == 3'd4)));

endmodule : sha_msg_padder
`default_nettype wire

// File: tb/tb_sha_msg_padder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sha_msg_padder : randomized scoreboard bench for sha_msg_padder   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sha_msg_padder;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         last;
    logic [63:0]  len;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_data;
  logic [2:0]   s_bytes;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] m_block;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_len_bits;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   bp_mode    = 1'b0;

  sha_msg_padder dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_bytes    (s_bytes),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_block    (m_block),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_len_bits (m_len_bits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: standard SHA-256 padding of a byte string, cut into 64-byte blocks.
  task automatic push_expected(input bq_t msg);
    bq_t         p;
    logic [63:0] bits;
    exp_t        e;
    int          nb;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int i = 0; i < 64; i++) e.blk[511 - 8 * i -: 8] = p[64 * b + i];
      e.last = (b == nb - 1);
      e.len  = bits;
      exp_q.push_back(e);
    end
  endtask

  task automatic make_msg(input int n, output bq_t m);
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
  endtask

  // Sends a message; stop_after >= 0 truncates it after that many words.
  task automatic send_msg(input bq_t msg, input int stop_after, input bit gaps);
    int n, nw, wait_n;
    logic [31:0] w;
    n  = msg.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int wi = 0; wi < nw; wi++) begin
      if (stop_after >= 0 && wi >= stop_after) break;
      for (int k = 0; k < 4; k++)
        w[31 - 8 * k -: 8] = (4 * wi + k < n) ? msg[4 * wi + k] : 8'($urandom);
      s_data  = w;
      s_last  = (wi == nw - 1);
      s_bytes = !s_last ? 3'd4 : (n == 0) ? 3'd0 : (n % 4 == 0) ? 3'd4 : 3'(n % 4);
      s_valid = 1'b1;
      wait_n  = 0;
      while (!s_ready && wait_n < 1000) begin
        @(negedge clk);
        wait_n++;
      end
      if (!s_ready) begin
        chk("s_ready_timeout", 1'b0, 1'b1);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = $urandom;
      if (s_last || (wi % 16 == 15)) chk("latency_m_valid", m_valid, 1'b1);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_msg(input bq_t m, input bit gaps);
    push_expected(m);
    send_msg(m, -1, gaps);
    drain();
  endtask

  // Monitor: drives m_ready, checks hold-stability and pops the scoreboard.
  initial begin
    int           wait_cnt = 0;
    bit           stalled  = 1'b0;
    logic [511:0] prev_blk;
    logic         prev_last;
    logic [63:0]  prev_len;
    exp_t         e;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled  = 1'b0;
        wait_cnt = 0;
        m_ready  = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", m_valid, 1'b1);
          chk("hold_block", m_block, prev_blk);
          chk("hold_last", m_last, prev_last);
          if (prev_last) chk("hold_len", m_len_bits, prev_len);
        end
        if (m_valid) begin
          chk("s_ready_low", s_ready, 1'b0);
          m_ready = bp_mode ? (wait_cnt >= 5) : ($urandom_range(0, 3) != 0);
          wait_cnt++;
          if (m_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_block", m_block, '0);
              chk("unexpected_valid", m_valid, 1'b0);
            end else begin
              e = exp_q.pop_front();
              chk("block", m_block, e.blk);
              chk("last", m_last, e.last);
              if (e.last) chk("len_bits", m_len_bits, e.len);
            end
            wait_cnt = 0;
            stalled  = 1'b0;
          end else begin
            stalled   = 1'b1;
            prev_blk  = m_block;
            prev_last = m_last;
            prev_len  = m_len_bits;
          end
        end else begin
          m_ready  = 1'(($urandom_range(0, 1)));
          stalled  = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin
    bq_t m;
    rst     = 1'b1;
    s_data  = '0;
    s_bytes = 3'd0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_m_last", m_last, 1'b0);
    chk("reset_m_block", m_block, '0);
    chk("reset_m_len_bits", m_len_bits, '0);
    chk("reset_s_ready", s_ready, 1'b1);

    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0);
    m = {};
    run_msg(m, 1'b0);

    bp_mode = 1'b1;
    make_msg(56, m);
    run_msg(m, 1'b0);
    bp_mode = 1'b0;

    make_msg(64, m);
    run_msg(m, 1'b0);
    make_msg(55, m);
    run_msg(m, 1'b1);
    make_msg(60, m);
    run_msg(m, 1'b1);

    // Abandon a message part-way through, then check nothing leaks out.
    make_msg(40, m);
    send_msg(m, 7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_m_valid", m_valid, 1'b0);
    chk("midreset_s_ready", s_ready, 1'b1);
    chk("midreset_len", m_len_bits, '0);
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0);

    for (int r = 0; r < 20; r++) begin
      make_msg($urandom_range(0, 140), m);
      run_msg(m, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sha_msg_padder
`default_nettype wire
